simon_round_dp: RTL and testbench

- Unshared SIMON128/128 round datapath. Sits directly downstream of the p_keysch10 key schedule and consumes its 64-bit `key_out` as the round key.
- Shares the same `clk`, `counter` and `data_rdy` controls and uses the same serial loading scheme.
- Loads a 128-bit plaintext bit-serially, runs 68 rounds (one round per two counter steps, in lock-step with the key update), then holds the ciphertext with a done flag.
- Supports a bit-serial ciphertext unload.

---
 rtl/simon_round_dp_if.sv | 25 ++
 rtl/simon_round_dp.sv | 90 +++++++++
 tb/tb_simon_round_dp.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/simon_round_dp_if.sv
// Bus bundle for the SIMON128/128 round datapath: control, serial data and round key in,
// state and status out.
interface simon_round_dp_if #(
    parameter int WORD = 64,
    parameter int CW   = 8
);
    logic                data_in;
    logic [1:0]          data_rdy;
    logic [CW-1:0]       counter;
    logic [WORD-1:0]     key_in;
    logic [2*WORD-1:0]   ct_out;
    logic                data_out;
    logic                done;
    logic                ct_valid;

    modport master (
        output data_in, data_rdy, counter, key_in,
        input  ct_out, data_out, done, ct_valid
    );

    modport slave (
        input  data_in, data_rdy, counter, key_in,
        output ct_out, data_out, done, ct_valid
    );
endinterface

// File: rtl/simon_round_dp.sv
// Unshared SIMON128/128 round datapath: serial plaintext load, one round per even counter
// step in lock-step with the key schedule, done/ct_valid flags and serial ciphertext unload.
module simon_round_dp #(
    parameter int WORD   = 64,
    parameter int ROUNDS = 68,
    parameter int CW     = 8
) (
    input  logic             clk,
    input  logic             rst,
    simon_round_dp_if.slave  bus
);
    localparam logic [CW-1:0] LAST_STEP = CW'(2 * ROUNDS - 2);

    localparam logic [1:0] MODE_IDLE = 2'd0;
    localparam logic [1:0] MODE_LOAD = 2'd1;
    localparam logic [1:0] MODE_KEY  = 2'd2;
    localparam logic [1:0] MODE_RUN  = 2'd3;

    logic [WORD-1:0] x_reg, x_next;
    logic [WORD-1:0] y_reg, y_next;
    logic            done_reg, done_next;
    logic            valid_reg, valid_next;

    logic [WORD-1:0] rot1, rot2, rot8, f_x;
    logic            round_fire;

    // Fixed left rotations are pure wiring: bit gi of S^j(x) is x[gi-j mod WORD].
    for (genvar gi = 0; gi < WORD; gi++) begin : g_rot
        assign rot1[gi] = x_reg[(gi + WORD - 1) % WORD];
        assign rot2[gi] = x_reg[(gi + WORD - 2) % WORD];
        assign rot8[gi] = x_reg[(gi + WORD - 8) % WORD];
    end

    assign f_x = (rot1 & rot8) ^ rot2;

    // Odd counter steps belong to the key update, so rounds only fire on even in-range steps.
    assign round_fire = (bus.data_rdy == MODE_RUN) && !bus.counter[0]
                        && (bus.counter <= LAST_STEP);

    always_comb begin
        x_next     = x_reg;
        y_next     = y_reg;
        done_next  = done_reg;
        valid_next = 1'b0;
        case (bus.data_rdy)
            MODE_LOAD: begin
                {x_next, y_next} = {bus.data_in, x_reg, y_reg[WORD-1:1]};
                done_next        = 1'b0;
            end
            MODE_KEY: begin
                done_next = 1'b0;
            end
            MODE_RUN: begin
                if (round_fire) begin
                    x_next = y_reg ^ f_x ^ bus.key_in;
                    y_next = x_reg;
                    if (bus.counter == LAST_STEP) begin
                        done_next  = 1'b1;
                        valid_next = 1'b1;
                    end
                end
            end
            default: begin
                if (done_reg) begin
                    {x_next, y_next} = {1'b0, x_reg, y_reg[WORD-1:1]};
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_reg     <= '0;
            y_reg     <= '0;
            done_reg  <= 1'b0;
            valid_reg <= 1'b0;
        end else begin
            x_reg     <= x_next;
            y_reg     <= y_next;
            done_reg  <= done_next;
            valid_reg <= valid_next;
        end
    end

    assign bus.ct_out   = {x_reg, y_reg};
    assign bus.data_out = y_reg[0];
    assign bus.done     = done_reg;
    assign bus.ct_valid = valid_reg;

endmodule

// File: tb/tb_simon_round_dp.sv
// Scoreboard bench for simon_round_dp: reset, serial load, known-answer run, overrun,
// serial unload and idle behaviour, with round keys from a bench-side key schedule model.
module tb_simon_round_dp;
    localparam logic [127:0] PT = 128'h6373656420737265_6c6c657661727420;
    localparam logic [127:0] CT = 128'h49681b1e1e54fe3f_65aa832af84e0bbc;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    logic [63:0]  keys [68];
    logic [127:0] exp_q [$];
    logic         bit_q [$];

    simon_round_dp_if bus ();

    simon_round_dp dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end else begin
            $display("ok   %s %h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] rotr(input logic [63:0] v, input int j);
        return (v >> j) | (v << (64 - j));
    endfunction

    task automatic build_keys();
        logic [61:0] z2;
        logic [63:0] tmp;
        int          zi;
        z2 = 62'b10101111011100000011010010011000101000010001111110010110110011;
        keys[0] = 64'h0706050403020100;
        keys[1] = 64'h0f0e0d0c0b0a0908;
        for (int i = 0; i < 66; i++) begin
            zi  = i % 62;
            tmp = rotr(keys[i+1], 3);
            tmp = tmp ^ rotr(tmp, 1);
            keys[i+2] = ~keys[i] ^ tmp ^ {63'd0, z2[61-zi]} ^ 64'd3;
        end
    endtask

    initial begin
        logic [127:0] pt_var;
        logic [127:0] ct_var;
        logic [127:0] held;
        logic         saw_valid;
        int           ki;

        checks = 0;
        errors = 0;
        build_keys();
        pt_var = PT;
        ct_var = CT;

        rst          = 1'b1;
        bus.data_in  = 1'b0;
        bus.data_rdy = 2'd0;
        bus.counter  = '0;
        bus.key_in   = '0;
        tick();
        check_val("reset_ct", bus.ct_out, 128'd0);
        check_val("reset_done", {127'd0, bus.done}, 128'd0);
        check_val("reset_valid", {127'd0, bus.ct_valid}, 128'd0);
        rst = 1'b0;
        tick();

        // Partial load then asynchronous reset between clock edges.
        bus.data_rdy = 2'd1;
        for (int i = 0; i < 40; i++) begin
            bus.data_in = 1'b1;
            tick();
        end
        check_val("partial_load_nonzero", {127'd0, (bus.ct_out != 128'd0)}, 128'd1);
        #2;
        rst = 1'b1;
        #1;
        check_val("async_rst_ct", bus.ct_out, 128'd0);
        check_val("async_rst_done", {127'd0, bus.done}, 128'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // Serial plaintext load, LSB of Y first.
        bus.data_rdy = 2'd1;
        for (int i = 0; i < 128; i++) begin
            bus.data_in = pt_var[i];
            tick();
        end
        exp_q.push_back(PT);
        check_val("load_ct", bus.ct_out, exp_q.pop_front());
        check_val("load_done", {127'd0, bus.done}, 128'd0);

        // Key schedule loading: this block holds.
        bus.data_rdy = 2'd2;
        for (int i = 0; i < 4; i++) tick();
        exp_q.push_back(PT);
        check_val("keyload_hold", bus.ct_out, exp_q.pop_front());

        // Odd counter parked in run mode: no rounds.
        bus.data_rdy = 2'd3;
        bus.counter  = 8'd1;
        bus.key_in   = keys[0];
        for (int i = 0; i < 10; i++) tick();
        exp_q.push_back(PT);
        check_val("odd_hold_ct", bus.ct_out, exp_q.pop_front());
        check_val("odd_hold_done", {127'd0, bus.done}, 128'd0);

        // Known-answer run, counter 0..135.
        for (int c = 0; c <= 135; c++) begin
            ki          = (c >> 1) > 67 ? 67 : (c >> 1);
            bus.counter = 8'(c);
            bus.key_in  = keys[ki];
            if (c == 134) exp_q.push_back(CT);
            tick();
            if (c == 132) begin
                check_val("pre_last_done", {127'd0, bus.done}, 128'd0);
                check_val("pre_last_valid", {127'd0, bus.ct_valid}, 128'd0);
            end
            if (c == 134) begin
                check_val("kat_ct", bus.ct_out, exp_q.pop_front());
                check_val("kat_done", {127'd0, bus.done}, 128'd1);
                check_val("kat_valid", {127'd0, bus.ct_valid}, 128'd1);
            end
            if (c == 135) begin
                check_val("valid_one_cycle", {127'd0, bus.ct_valid}, 128'd0);
            end
        end

        // Overrun beyond the last round.
        saw_valid = 1'b0;
        for (int c = 136; c <= 200; c++) begin
            bus.counter = 8'(c);
            bus.key_in  = keys[67];
            tick();
            saw_valid = saw_valid | bus.ct_valid;
        end
        exp_q.push_back(CT);
        check_val("overrun_ct", bus.ct_out, exp_q.pop_front());
        check_val("overrun_done", {127'd0, bus.done}, 128'd1);
        check_val("overrun_no_valid", {127'd0, saw_valid}, 128'd0);

        // Serial unload, ciphertext LSB first.
        bus.data_rdy = 2'd0;
        for (int i = 0; i < 128; i++) begin
            bit_q.push_back(ct_var[i]);
            check_val($sformatf("unload_bit%0d", i), {127'd0, bus.data_out},
                      {127'd0, bit_q.pop_front()});
            tick();
        end
        check_val("unload_empty", bus.ct_out, 128'd0);
        check_val("unload_done_kept", {127'd0, bus.done}, 128'd1);

        // Leaving to load mode clears done on the next edge.
        bus.data_rdy = 2'd1;
        bus.data_in  = 1'b1;
        tick();
        check_val("load_clears_done", {127'd0, bus.done}, 128'd0);
        held = 128'd1 << 127;
        exp_q.push_back(held);
        check_val("one_bit_loaded", bus.ct_out, exp_q.pop_front());

        // Idle with done low: state held.
        bus.data_rdy = 2'd0;
        bus.data_in  = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        exp_q.push_back(held);
        check_val("idle_hold_ct", bus.ct_out, exp_q.pop_front());
        check_val("idle_hold_done", {127'd0, bus.done}, 128'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
